// File: rtl/neuron_fx_pkg.sv
// neuron_fx_pkg: shared Q3.12 sign-magnitude constants and neuron FSM state encoding
package neuron_fx_pkg;
    localparam int          FX_W       = 16;
    localparam int          FX_FRAC    = 12;
    localparam logic [14:0] FX_MAG_MAX = 15'h7FFF;
    localparam logic [15:0] FX_ONE     = 16'h1000;
    localparam logic [15:0] FX_ZERO    = 16'h0000;
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACT, S_DONE} state_e;
endpackage

// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if: control, pair-stream and result handshakes between the layer sequencer and one neuron
interface neuron_mac_seq_if
    import neuron_fx_pkg::*;
#(
    parameter int CNT_W = 5
);
    logic             start;
    logic [CNT_W-1:0] n_inputs;
    logic [FX_W-1:0]  bias;
    logic             act_sel;
    logic             in_valid;
    logic             in_ready;
    logic [FX_W-1:0]  x;
    logic [FX_W-1:0]  w;
    logic             out_valid;
    logic             out_ready;
    logic [FX_W-1:0]  y;
    logic             busy;
    logic             sat_flag;
    modport master (
        output start, n_inputs, bias, act_sel, in_valid, x, w, out_ready,
        input  in_ready, out_valid, y, busy, sat_flag
    );
    modport slave (
        input  start, n_inputs, bias, act_sel, in_valid, x, w, out_ready,
        output in_ready, out_valid, y, busy, sat_flag
    );
endinterface

// File: rtl/neuron_fx_mac_dp.sv
// neuron_fx_mac_dp: saturating sign-magnitude multiply of x*w added into acc
module neuron_fx_mac_dp
    import neuron_fx_pkg::*;
(
    input  logic [FX_W-1:0] acc_i,
    input  logic [FX_W-1:0] x_i,
    input  logic [FX_W-1:0] w_i,
    output logic [FX_W-1:0] next_acc_o,
    output logic            sat_o
);
    logic [29:0]     p;
    logic            zero, mul_ovf, add_ovf, same, a_ge;
    logic [14:0]     mul_mag, diff;
    logic [FX_W-1:0] prod, sum;

    // product truncated to Q3.12, then sign-magnitude add with magnitude clamp
    always_comb begin
        p          = 30'(x_i[14:0]) * 30'(w_i[14:0]);
        zero       = (x_i == FX_ZERO) || (w_i == FX_ZERO);
        mul_ovf    = !zero && (|p[29:27]);
        mul_mag    = 15'(p >> FX_FRAC);
        prod       = zero ? FX_ZERO : {x_i[15] ^ w_i[15], mul_ovf ? FX_MAG_MAX : mul_mag};
        same       = acc_i[15] == prod[15];
        sum        = {1'b0, acc_i[14:0]} + {1'b0, prod[14:0]};
        add_ovf    = same && sum[15];
        a_ge       = acc_i[14:0] >= prod[14:0];
        diff       = a_ge ? acc_i[14:0] - prod[14:0] : prod[14:0] - acc_i[14:0];
        next_acc_o = same ? {acc_i[15], add_ovf ? FX_MAG_MAX : sum[14:0]}
                          : ((diff == '0) ? FX_ZERO : {a_ge ? acc_i[15] : prod[15], diff});
        sat_o      = mul_ovf | add_ovf;
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential neuron - bias plus streamed x*w products, optional ReLU, handshaked result
module neuron_mac_seq
    import neuron_fx_pkg::*;
#(
    parameter int N_MAX = 16,
    parameter int CNT_W = 5
)(
    input logic              clk,
    input logic              rst_n,
    neuron_mac_seq_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'(S_IDLE);
    localparam logic [1:0] ACC  = 2'(S_ACC);
    localparam logic [1:0] ACT  = 2'(S_ACT);
    localparam logic [1:0] DONE = 2'(S_DONE);

    logic [1:0]       state_q, state_d;
    logic [FX_W-1:0]  acc_q, y_q, mac_acc;
    logic [CNT_W-1:0] cnt_q, n_q, n_clamp;
    logic             act_q, sat_q, ov_q, mac_sat, accept, last;

    neuron_fx_mac_dp u_dp (
        .acc_i      (acc_q),
        .x_i        (bus.x),
        .w_i        (bus.w),
        .next_acc_o (mac_acc),
        .sat_o      (mac_sat)
    );

    assign n_clamp       = (bus.n_inputs > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : bus.n_inputs;
    assign accept        = (state_q == ACC) && bus.in_valid;
    assign last          = cnt_q == n_q - 1'b1;
    assign bus.in_ready  = state_q == ACC;
    assign bus.out_valid = ov_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.y         = y_q;
    assign bus.sat_flag  = sat_q;

    // FSM transitions; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = (n_clamp == '0) ? ACT : ACC;
            ACC:     if (accept && last) state_d = ACT;
            ACT:     state_d = DONE;
            DONE:    if (ov_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, accumulator, result and sticky saturation; out_valid lags DONE entry by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= FX_ZERO;
            y_q     <= FX_ZERO;
            cnt_q   <= '0;
            n_q     <= '0;
            act_q   <= 1'b0;
            sat_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                n_q   <= n_clamp;
                acc_q <= bus.bias;
                act_q <= bus.act_sel;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end
            if (accept) begin
                acc_q <= mac_acc;
                cnt_q <= cnt_q + 1'b1;
                sat_q <= sat_q | mac_sat;
            end
            if (state_q == ACT) y_q <= (acc_q[15] && (act_q || acc_q[14:0] == '0)) ? FX_ZERO : acc_q;
            ov_q <= (state_q == DONE) && !(ov_q && bus.out_ready);
        end
    end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Sequential neuron core. It accepts a stream of (input, weight) pairs in 16-bit sign-magnitude Q3.12 over a valid/ready handshake.
- Each accepted pair is multiplied and the product is added into a running sum that starts from a bias value.
- After the last pair, an optional ReLU is applied and the neuron output is presented on an output valid/ready handshake.
- The block drives the fixed-point multiply/add stage and consumes its results. It is the per-neuron controller placed between the layer sequencer and the activation/output buffer.

Parameters:
- N_MAX, 16, maximum number of input pairs per neuron evaluation.
- CNT_W, 5, width of n_inputs and of the internal pair counter; must hold N_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an evaluation; sampled only in IDLE.
- n_inputs  in  CNT_W  number of pairs; latched on an accepted start.
- bias  in  16  Q3.12 sign-magnitude bias; latched on an accepted start.
- act_sel  in  1  0 = identity, 1 = ReLU; latched on an accepted start.
- in_valid  in  1  x/w pair valid.
- in_ready  out  1  block can accept a pair.
- x  in  16  input operand, sign-magnitude Q3.12.
- w  in  16  weight operand, sign-magnitude Q3.12.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.
- y  out  16  neuron result, sign-magnitude Q3.12.
- busy  out  1  high in any state other than IDLE.
- sat_flag  out  1  sticky: a saturation occurred in the current or last evaluation.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: state = IDLE; acc, y, cnt = 0; in_ready, out_valid, busy, sat_flag = 0. Reset asserted mid-evaluation discards all progress immediately.
- FSM states: IDLE, ACC, ACT, DONE.
- IDLE:
  - On start, latch n_inputs, bias and act_sel; set acc <= bias, cnt <= 0, sat_flag <= 0.
  - n_inputs > N_MAX is clamped to N_MAX.
  - If n_inputs == 0, go to ACT; otherwise go to ACC.
- ACC:
  - in_ready = 1.
  - On in_valid & in_ready: acc <= sat_add(acc, sat_mul(x, w)); cnt <= cnt + 1.
  - When the accepted pair is pair number n-1 (the last), go to ACT.
  - With no in_valid, stay in ACC with acc held. Gaps in in_valid are allowed.
- ACT (one cycle):
  - in_ready = 0.
  - y <= 0x0000 when act_sel = 1 and acc is negative-nonzero; otherwise y <= acc.
  - Any 0x8000 result (negative zero) is normalised to 0x0000.
  - Go to DONE.
- DONE:
  - out_valid = 1; y is held stable until out_ready.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
  - start is ignored here and in every state except IDLE.
- Latency: the last pair is accepted at edge k, y is registered at edge k+1, and out_valid is high from edge k+2. Throughput is one pair per cycle in ACC.
- sat_mul(x, w):
  - Result is 0x0000 if x == 0x0000 or w == 0x0000.
  - Otherwise sign = x[15] ^ w[15], P = x[14:0] * w[14:0] (30 bits), magnitude = P[26:12] (truncate).
  - If P[29:27] != 0, magnitude = 0x7FFF and sat_flag <= 1.
- sat_add(a, b):
  - Same sign: 16-bit magnitude sum. If bit 15 is set, magnitude = 0x7FFF and sat_flag <= 1. Sign is kept.
  - Different signs, equal magnitudes: result 0x0000.
  - Different signs, unequal magnitudes: larger minus smaller, taking the sign of the larger.
- sat_flag stays high until the next accepted start.

Decomposition:
- Package neuron_fx_pkg holds:
  - FX_W = 16, FX_FRAC = 12, FX_MAG_MAX = 15'h7FFF, FX_ONE = 16'h1000, FX_ZERO = 16'h0000.
  - State enum for IDLE/ACC/ACT/DONE.
- One combinational sub-module, neuron_fx_mac_dp: inputs acc, x, w; outputs next_acc and sat. It implements sat_mul followed by sat_add.
- The FSM, counter and handshakes live in neuron_mac_seq.

Test Plan:
- Mixed-sign sum: n=3, bias=0x0000, act_sel=0, pairs (0x1000,0x0800), (0x2000,0x0800), (0x9000,0x0800) on consecutive cycles -> y=0x1000, sat_flag=0, out_valid two cycles after the last accept.
- ReLU: n=2, bias=0, pairs (0x9000,0x2000), (0x1000,0x0800) -> act_sel=0 gives y=0x9800; act_sel=1 gives y=0x0000.
- Saturation:
  - bias=0x7000, n=1, pair (0x1000,0x2000) -> y=0x7FFF, sat_flag=1.
  - n=1, bias=0, pair (0x4000,0x4000) -> y=0x7FFF, sat_flag=1.
  - A following clean start clears sat_flag.
- Handshakes: in_valid with 3-cycle gaps, out_ready held low for 5 cycles -> y and out_valid stable throughout; start pulses in ACC/DONE ignored; result is identical to the gap-free run.
- Edge cases:
  - n=0, bias=0x8800 -> act_sel=0 gives y=0x8800; act_sel=1 gives 0x0000.
  - Exact cancellation, bias 0x0800 plus pair (0x8800,0x1000) -> y=0x0000, never 0x8000.
- Reset mid-evaluation: rst_n low after 2 of 4 pairs -> all outputs 0 asynchronously, state IDLE; a new start then yields the correct fresh result.
